multicycle_ctrl: RTL and testbench

//  Multicycle control unit for the RV32I datapath; sits directly upstream of it.

---
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: latches the fetched instruction and walks it
// through IF/ID/EX/MEM/WB, Moore-decoding datapath controls from state and ir.
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        loadPC,
    output logic [3:0]  ALUCtrl,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        zero_q, zero_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r, is_i, is_lw, is_sw, is_beq;
    logic       alu_ok;
    logic [3:0] alu_code;
    logic       unused_ir;

    assign op     = ir_q[6:0];
    assign f3     = ir_q[14:12];
    assign f7     = ir_q[31:25];
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_beq = (op == OP_BEQ);

    // Register indices and immediates belong to the datapath, not to control.
    assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IF: begin
                ir_d    = instr;
                state_d = S_ID;
            end
            S_ID: state_d = S_EX;
            S_EX: begin
                zero_d  = Zero;
                cnt_d   = (is_lw || is_sw) ? WAIT_LD : 4'd0;
                state_d = S_MEM;
            end
            S_MEM: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = S_WB;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        alu_code = ALU_ADD;
        alu_ok   = 1'b1;
        unique case (1'b1)
            is_r, is_i: begin
                unique case (f3)
                    3'b000: alu_code = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_code = ALU_SLL;
                    3'b010: alu_code = ALU_SLT;
                    3'b100: alu_code = ALU_XOR;
                    3'b101: alu_code = ir_q[30] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_code = ALU_OR;
                    3'b111: alu_code = ALU_AND;
                    default: alu_ok  = 1'b0;
                endcase
                // funct7 must be zero except the ADD/SUB and SRL/SRA alternates.
                if (is_r) begin
                    if (!(f7 == 7'h00 ||
                          (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
                        alu_ok = 1'b0;
                end else begin
                    if (f3 == 3'b001 && f7 != 7'h00)
                        alu_ok = 1'b0;
                    if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
                        alu_ok = 1'b0;
                end
            end
            is_beq:  alu_code = ALU_SUB;
            default: alu_code = ALU_ADD;
        endcase
        if (!alu_ok) alu_code = ALU_ADD;
    end

    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        loadPC   = 1'b0;
        ALUCtrl  = 4'b0000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (state_q != S_IF) begin
            ALUSrc   = is_i || is_lw || is_sw;
            ALUCtrl  = alu_code;
            MemToReg = is_lw;
        end
        if (state_q == S_MEM) begin
            MemRead  = is_lw;
            MemWrite = is_sw;
        end
        if (state_q == S_WB) begin
            loadPC   = 1'b1;
            RegWrite = ((is_r || is_i) && alu_ok) || is_lw;
            PCSrc    = is_beq && zero_q;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: spec vectors, corner sequences and random
// instructions checked against a per-cycle behavioural model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcsrc;
        logic       alusrc;
        logic       regwrite;
        logic       memtoreg;
        logic       loadpc;
        logic [3:0] aluctrl;
        logic       memread;
        logic       memwrite;
        logic [2:0] st;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        zero;
        logic [3:0]  ex_alu;
        logic        ex_src;
        logic        wb_rw;
        logic        wb_pcsrc;
        int          rd_n;
        int          wr_n;
        int          cpi;
    } vec_t;

    logic        clk;
    logic        rst2, rst0;
    logic [31:0] instr;
    logic        zero_in;

    logic       pcsrc2, alusrc2, regw2, m2r2, ldpc2, mrd2, mwr2;
    logic [3:0] alu2;
    logic [2:0] st2;
    logic       pcsrc0, alusrc0, regw0, m2r0, ldpc0, mrd0, mwr0;
    logic [3:0] alu0;
    logic [2:0] st0;
    outs_t      o2, o0;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.MEM_WAIT(2)) u2 (
        .clk(clk), .rst(rst2), .instr(instr), .Zero(zero_in),
        .PCSrc(pcsrc2), .ALUSrc(alusrc2), .RegWrite(regw2),
        .MemToReg(m2r2), .loadPC(ldpc2), .ALUCtrl(alu2),
        .MemRead(mrd2), .MemWrite(mwr2), .state_o(st2)
    );

    multicycle_ctrl #(.MEM_WAIT(0)) u0 (
        .clk(clk), .rst(rst0), .instr(instr), .Zero(zero_in),
        .PCSrc(pcsrc0), .ALUSrc(alusrc0), .RegWrite(regw0),
        .MemToReg(m2r0), .loadPC(ldpc0), .ALUCtrl(alu0),
        .MemRead(mrd0), .MemWrite(mwr0), .state_o(st0)
    );

    assign o2 = {pcsrc2, alusrc2, regw2, m2r2, ldpc2, alu2, mrd2, mwr2, st2};
    assign o0 = {pcsrc0, alusrc0, regw0, m2r0, ldpc0, alu0, mrd0, mwr0, st0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_v(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic chk_o(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Expected outputs during cycle k (0 = IF) of one instruction.
    function automatic outs_t exp_out(input logic [31:0] ins, input logic z,
                                      input int w, input int k);
        outs_t      e;
        logic [3:0] base [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit         r, i, lw, sw, bq, ok;
        logic [3:0] code;
        int         m, st;
        base = '{4'b0010, 4'b1001, 4'b0111, 4'b0010,
                 4'b1101, 4'b1000, 4'b0001, 4'b0000};
        e  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        r  = (op == 7'h33);
        i  = (op == 7'h13);
        lw = (op == 7'h03);
        sw = (op == 7'h23);
        bq = (op == 7'h63);
        m  = (lw || sw) ? w + 1 : 1;
        st = (k < 3) ? k : ((k < 3 + m) ? 3 : 4);
        ok = 1;
        code = 4'b0010;
        if (bq) code = 4'b0110;
        if (r) begin
            ok = (f3 != 3) && (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            code = (f7 == 7'h20) ? ((f3 == 0) ? 4'b0110 : 4'b1010) : base[f3];
        end
        if (i) begin
            ok = (f3 != 3);
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
            code = (f3 == 5 && f7 == 7'h20) ? 4'b1010 : base[f3];
        end
        if (!ok) code = 4'b0010;
        e.st = st[2:0];
        if (st != 0) begin
            e.alusrc   = i || lw || sw;
            e.aluctrl  = code;
            e.memtoreg = lw;
        end
        if (st == 3) begin
            e.memread  = lw;
            e.memwrite = sw;
        end
        if (st == 4) begin
            e.loadpc   = 1'b1;
            e.regwrite = ((r || i) && ok) || lw;
            e.pcsrc    = bq && z;
        end
        return e;
    endfunction

    // Starts before the IF-cycle negedge, ends at the WB negedge.
    task automatic run_model(input bit sel0, input logic [31:0] ins,
                             input logic z, input int w);
        int    n;
        outs_t got;
        logic [6:0] op;
        op = ins[6:0];
        n = (op == 7'h03 || op == 7'h23) ? 5 + w : 5;
        instr   = ins;
        zero_in = z;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            got = sel0 ? o0 : o2;
            chk_o($sformatf("model ins=%h k=%0d", ins, k), got,
                  exp_out(ins, z, w, k));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, rd_n, wr_n, bad;
        logic ex_seen, wb_seen;
        logic [3:0] ex_alu;
        logic ex_src, wb_rw, wb_pc;
        cyc = 0; rd_n = 0; wr_n = 0; bad = 0;
        ex_seen = 0; wb_seen = 0;
        ex_alu = 'x; ex_src = 'x; wb_rw = 'x; wb_pc = 'x;
        instr   = v.ins;
        zero_in = v.zero;
        for (int c = 0; c < 24 && !wb_seen; c++) begin
            @(negedge clk);
            cyc++;
            if (st2 == 3'd2) begin
                ex_seen = 1; ex_alu = alu2; ex_src = alusrc2;
            end
            if (mrd2) rd_n++;
            if (mwr2) wr_n++;
            if (st2 != 3'd4 && (regw2 || ldpc2 || pcsrc2)) bad++;
            if (st2 == 3'd4) begin
                wb_seen = 1; wb_rw = regw2; wb_pc = pcsrc2;
                if (!ldpc2) bad++;
            end
        end
        chk_v({v.name, " reached WB"}, int'(wb_seen && ex_seen), 1);
        chk_v({v.name, " EX ALUCtrl"}, int'(ex_alu), int'(v.ex_alu));
        chk_v({v.name, " EX ALUSrc"}, int'(ex_src), int'(v.ex_src));
        chk_v({v.name, " WB RegWrite"}, int'(wb_rw), int'(v.wb_rw));
        chk_v({v.name, " WB PCSrc"}, int'(wb_pc), int'(v.wb_pcsrc));
        chk_v({v.name, " MemRead cycles"}, rd_n, v.rd_n);
        chk_v({v.name, " MemWrite cycles"}, wr_n, v.wr_n);
        chk_v({v.name, " CPI"}, cyc, v.cpi);
        chk_v({v.name, " stray pulses"}, bad, 0);
    endtask

    // beq whose Zero is high only during EX (or only outside EX).
    task automatic beq_zero_window(input logic in_ex, input logic exp_pc);
        logic pc, seen;
        pc = 'x; seen = 0;
        instr   = 32'h00000063;
        zero_in = ~in_ex;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (st2 == 3'd2) zero_in = in_ex;
            if (st2 == 3'd3) zero_in = ~in_ex;
            if (st2 == 3'd4) begin
                seen = 1; pc = pcsrc2;
            end
        end
        chk_v($sformatf("beq zero-in-EX=%0d PCSrc", in_ex), int'(pc), int'(exp_pc));
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] ins;
        int kind, f7s;
        ins  = $urandom;
        kind = $urandom_range(0, 5);
        f7s  = $urandom_range(0, 3);
        case (kind)
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h23;
            4: ins[6:0] = 7'h63;
            default: begin
                if (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63})
                    ins[6:0] = 7'h7F;
            end
        endcase
        if (f7s < 2)       ins[31:25] = 7'h00;
        else if (f7s == 2) ins[31:25] = 7'h20;
        return ins;
    endfunction

    vec_t vecs [12];
    outs_t got;
    int bad;

    initial begin
        vecs[0]  = '{"addi",   32'h00500093, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 0, 0, 5};
        vecs[1]  = '{"beq z1", 32'h00000063, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 0, 0, 5};
        vecs[2]  = '{"beq z0", 32'h00000063, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 0, 0, 5};
        vecs[3]  = '{"lw",     32'h0000A103, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 3, 0, 7};
        vecs[4]  = '{"sw",     32'h0020A023, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 3, 7};
        vecs[5]  = '{"sub",    32'h402081B3, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 0, 0, 5};
        vecs[6]  = '{"sra",    32'h4020D1B3, 1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 0, 0, 5};
        vecs[7]  = '{"slt",    32'h0020A1B3, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 0, 0, 5};
        vecs[8]  = '{"xor",    32'h0020C1B3, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b0, 0, 0, 5};
        vecs[9]  = '{"srai",   32'h4030D193, 1'b0, 4'b1010, 1'b1, 1'b1, 1'b0, 0, 0, 5};
        vecs[10] = '{"nop7f",  32'h0000007F, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 0, 5};
        vecs[11] = '{"sltu",   32'h0020B1B3, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 0, 5};

        rst2 = 1'b1;
        rst0 = 1'b1;
        instr = 32'h0;
        zero_in = 1'b0;
        #12;
        chk_o("reset outputs", o2, '0);
        @(posedge clk);
        #1 rst2 = 1'b0;

        foreach (vecs[v]) run_vec(vecs[v]);

        beq_zero_window(1'b1, 1'b1);
        beq_zero_window(1'b0, 1'b0);

        for (int t = 0; t < 40; t++)
            run_model(1'b0, rand_ins(), 1'($urandom), 2);

        // Abort an add in EX: outputs clear immediately, no WB pulses.
        instr = 32'h002081B3;
        repeat (3) @(negedge clk);
        chk_v("pre-abort state EX", int'(st2), 2);
        #1 rst2 = 1'b1;
        #1 chk_o("async reset in EX", o2, '0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (o2 !== '0) bad++;
        end
        chk_v("held reset no pulses", bad, 0);
        @(posedge clk);
        #1 rst2 = 1'b0;
        run_model(1'b0, 32'h00500093, 1'b0, 2);

        @(posedge clk);
        #1 rst0 = 1'b1;
        rst0 = 1'b0;
        run_model(1'b1, 32'h0000A103, 1'b0, 0);
        run_model(1'b1, 32'h0020A023, 1'b0, 0);
        for (int t = 0; t < 20; t++)
            run_model(1'b1, rand_ins(), 1'($urandom), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
